attention_dot_acc: RTL and testbench

- Streaming accumulator directly downstream of attention_mul_32s_32s_32_2_1; sums the signed 32-bit element products of one attention dot product (one Q·K row/column pair).
- Each vector is a stream of product beats; a beat with in_last closes the vector.
- At that point the sum is scaled by an arithmetic right shift, saturated to OUT_WIDTH, and presented as one score on a valid/ready output with a one-entry holding buffer.
- Feeds the softmax stage.

---
 rtl/attention_dot_acc.sv | 132 +++++++++++++
 tb/tb_attention_dot_acc.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/attention_dot_acc.sv
// attention_dot_acc
// Streaming accumulator for one attention dot product. Signed product beats
// are summed at ACC_WIDTH. The beat flagged in_last closes the vector: the
// sum is arithmetically shifted right by SHIFT, saturated to OUT_WIDTH, and
// parked in a one-entry output buffer with a valid/ready handshake. A closing
// beat may reload the buffer in the same cycle the previous score leaves, so
// consecutive scores flow without a bubble.
module attention_dot_acc #(
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 32,
  parameter int SHIFT     = 8,
  parameter int MAX_LEN   = 1024,
  parameter int CNT_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_sat,
  output logic                 err_len
);

  // Saturation bounds expressed at accumulator width so they compare
  // directly against the scaled sum.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(MAX_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ALL_ONES = {CNT_WIDTH{1'b1}};

  // Clip a scaled sum to the signed output range; returns {clipped, value}.
  function automatic logic [OUT_WIDTH:0] saturate(input logic signed [ACC_WIDTH-1:0] value);
    logic [OUT_WIDTH:0] result;
    if (value > SAT_MAX) begin
      result = {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
    end else if (value < SAT_MIN) begin
      result = {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
    end else begin
      result = {1'b0, value[OUT_WIDTH-1:0]};
    end
    return result;
  endfunction

  logic signed [ACC_WIDTH-1:0] acc_r;
  logic [CNT_WIDTH-1:0]        cnt_r;

  logic                        accept_s;
  logic signed [ACC_WIDTH-1:0] in_ext_s;
  logic signed [ACC_WIDTH-1:0] sum_s;
  logic signed [ACC_WIDTH-1:0] scaled_s;
  logic [OUT_WIDTH:0]          sat_s;
  logic [CNT_WIDTH-1:0]        cnt_inc_s;
  logic                        len_over_s;

  // The buffer frees up either when empty or when its score leaves this cycle.
  assign in_ready = !out_valid || out_ready;

  // Datapath: extend, add, rescale and clip the running sum for this beat.
  always_comb begin
    accept_s   = in_valid && in_ready;
    in_ext_s   = ACC_WIDTH'($signed(in_data));
    sum_s      = acc_r + in_ext_s;
    scaled_s   = sum_s >>> SHIFT;
    sat_s      = saturate(scaled_s);
    // Hold the counter at all-ones rather than wrap if a runaway vector
    // outlives the counter; err_len has already flagged it by then.
    if (cnt_r == CNT_ALL_ONES) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
    len_over_s = accept_s && !in_last && (cnt_r == CNT_LIMIT);
  end

  // Running sum and beat count of the vector currently streaming in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r <= '0;
      cnt_r <= '0;
    end else if (accept_s) begin
      if (in_last) begin
        acc_r <= '0;
        cnt_r <= '0;
      end else begin
        acc_r <= sum_s;
        cnt_r <= cnt_inc_s;
      end
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end

  // Sticky flag for a vector running past MAX_LEN beats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_len <= 1'b0;
    end else if (len_over_s) begin
      err_len <= 1'b1;
    end else begin
      err_len <= err_len;
    end
  end

  // One-entry output buffer: load on a closing beat, empty on transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else if (accept_s && in_last) begin
      out_valid <= 1'b1;
      out_data  <= sat_s[OUT_WIDTH-1:0];
      out_count <= cnt_inc_s;
      out_sat   <= sat_s[OUT_WIDTH];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_attention_dot_acc.sv
// Directed bench for attention_dot_acc. Two instances share one input
// stream: ua uses the default parameters (SHIFT=8, MAX_LEN=1024) and ub uses
// SHIFT=0, MAX_LEN=4, so each vector exercises both scaling and saturation /
// length-error behaviour. Expected values are hand-computed constants.
module tb_attention_dot_acc;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        a_in_ready, b_in_ready;
  logic        a_out_valid, b_out_valid;
  logic [31:0] a_out_data, b_out_data;
  logic [10:0] a_out_count, b_out_count;
  logic        a_out_sat, b_out_sat;
  logic        a_err_len, b_err_len;

  int checks_total;
  int checks_passed;

  attention_dot_acc ua (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_count(a_out_count), .out_sat(a_out_sat), .err_len(a_err_len)
  );

  attention_dot_acc #(.SHIFT(0), .MAX_LEN(4)) ub (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_count(b_out_count), .out_sat(b_out_sat), .err_len(b_err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks_total++;
    if (obs == exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Present one beat from a negedge, wait (bounded) for acceptance, and
  // return at the negedge after the accepting edge with in_valid dropped.
  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!(a_in_ready && b_in_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", longint'(n), 64'sd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_score(input string tag, input longint a_d, input longint b_d,
                              input longint cnt, input longint a_s, input longint b_s);
    check({tag, "_a_valid"}, longint'(a_out_valid), 64'sd1);
    check({tag, "_b_valid"}, longint'(b_out_valid), 64'sd1);
    check({tag, "_a_data"},  longint'($signed(a_out_data)), a_d);
    check({tag, "_b_data"},  longint'($signed(b_out_data)), b_d);
    check({tag, "_a_count"}, longint'(a_out_count), cnt);
    check({tag, "_b_count"}, longint'(b_out_count), cnt);
    check({tag, "_a_sat"},   longint'(a_out_sat), a_s);
    check({tag, "_b_sat"},   longint'(b_out_sat), b_s);
  endtask

  // One idle cycle with out_ready high; the buffer must have emptied.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_drained"}, longint'(a_out_valid | b_out_valid), 64'sd0);
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_out_valid", longint'(a_out_valid | b_out_valid), 64'sd0);
    check("rst_out_data",  longint'(a_out_data | b_out_data), 64'sd0);
    check("rst_out_count", longint'(a_out_count | b_out_count), 64'sd0);
    check("rst_out_sat",   longint'(a_out_sat | b_out_sat), 64'sd0);
    check("rst_err_len",   longint'(a_err_len | b_err_len), 64'sd0);
    check("rst_in_ready",  longint'(a_in_ready & b_in_ready), 64'sd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset mid-vector discards the partial sum
    for (int i = 0; i < 3; i++) send(32'd1000, 1'b0);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", longint'(a_out_valid | b_out_valid), 64'sd0);
    check("midrst_in_ready",  longint'(a_in_ready & b_in_ready), 64'sd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(32'd256, 1'b0);
    send(32'd256, 1'b1);
    expect_score("after_rst", 64'sd2, 64'sd512, 64'sd2, 64'sd0, 64'sd0);
    drain("after_rst");

    // Basic sum: 65536 - 256 + 512 = 65792; >>>8 = 257
    send(32'd65536, 1'b0);
    send(-32'sd256, 1'b0);
    send(32'd512, 1'b1);
    expect_score("basic", 64'sd257, 64'sd65792, 64'sd3, 64'sd0, 64'sd0);
    drain("basic");

    // Positive saturation: 4 * (2^31-1) = 0x1_FFFF_FFFC
    for (int i = 0; i < 4; i++) send(32'h7FFF_FFFF, (i == 3));
    expect_score("sat_pos", 64'sd33554431, 64'sd2147483647, 64'sd4, 64'sd0, 64'sd1);
    check("sat_pos_b_err", longint'(b_err_len), 64'sd0);
    drain("sat_pos");

    // Negative saturation: 4 * -2^31 = -2^33
    for (int i = 0; i < 4; i++) send(32'h8000_0000, (i == 3));
    expect_score("sat_neg", -64'sd33554432, -64'sd2147483648, 64'sd4, 64'sd0, 64'sd1);
    drain("sat_neg");

    // Floor rounding on a single-beat vector
    send(32'hFFFF_FFFF, 1'b1);
    expect_score("neg_round", -64'sd1, -64'sd1, 64'sd1, 64'sd0, 64'sd0);
    drain("neg_round");

    // Backpressure: score 3000 held while the next vector waits
    out_ready = 1'b0;
    send(32'd1000, 1'b0);
    send(32'd2000, 1'b1);
    expect_score("bp_first", 64'sd11, 64'sd3000, 64'sd2, 64'sd0, 64'sd0);
    in_valid = 1'b1;
    in_data  = 32'd5000;
    in_last  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_in_ready", longint'(a_in_ready | b_in_ready), 64'sd0);
      expect_score("bp_hold", 64'sd11, 64'sd3000, 64'sd2, 64'sd0, 64'sd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_released", longint'(a_out_valid | b_out_valid), 64'sd0);
    send(32'd7000, 1'b1);
    expect_score("bp_second", 64'sd46, 64'sd12000, 64'sd2, 64'sd0, 64'sd0);

    // Back-to-back: out_ready rises in the cycle the next last beat waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd256;
    in_last   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b2b_in_ready", longint'(a_in_ready | b_in_ready), 64'sd0);
    expect_score("b2b_hold", 64'sd46, 64'sd12000, 64'sd2, 64'sd0, 64'sd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    expect_score("b2b_new", 64'sd1, 64'sd256, 64'sd1, 64'sd0, 64'sd0);
    drain("b2b");

    // Length error on ub (MAX_LEN=4): five beats of 1
    for (int i = 0; i < 5; i++) send(32'd1, (i == 4));
    expect_score("len", 64'sd0, 64'sd5, 64'sd5, 64'sd0, 64'sd0);
    check("len_b_err", longint'(b_err_len), 64'sd1);
    check("len_a_err", longint'(a_err_len), 64'sd0);
    drain("len");
    send(32'd3, 1'b1);
    expect_score("len_after", 64'sd0, 64'sd3, 64'sd1, 64'sd0, 64'sd0);
    check("len_sticky", longint'(b_err_len), 64'sd1);
    drain("len_after");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
